flash_controller: RTL and testbench
===================================

Name: flash_controller

Overview:
- Bus_if slave that maps CPU data-bus reads and writes onto the board's 16-bit parallel NOR flash, which is driven through the Flash_if pins.
- Sits behind data_bus on its flash port.
- Each 32-bit read is built from two consecutive 16-bit flash reads.
- Writes issue single 16-bit command/data cycles, as used for CFI program/erase sequences.
- Stall is held while the flash access is in progress.

Parameters:
- READ_WAIT, 8: clocks oe_n/ce_n are held low per halfword read before data is sampled (min 1).
- WRITE_WAIT, 8: clocks we_n is held low per halfword write (min 1).
- ADDR_WIDTH, 23: flash byte-address width; bit 0 is unused in 16-bit mode.

Ports:
- clk, in, 1: clock; all logic on rising edge.
- rst_n, in, 1: asynchronous active-low reset.
- bus_read, in, 1: Bus_if read request.
- bus_write, in, 1: Bus_if write request.
- bus_address, in, 32: byte address; bits [ADDR_WIDTH-1:0] are used.
- bus_data_wr, in, 32: write data.
- bus_mask, in, 4: byte mask; writes proceed when any of bits [1:0] is set.
- bus_data_rd, out, 32: read data.
- bus_stall, out, 1: request not yet complete.
- flash_address, out, ADDR_WIDTH: byte address; bit 0 is always 0.
- flash_data, inout, 16: flash data bus.
- flash_ce_n, out, 1: chip enable.
- flash_oe_n, out, 1: output enable.
- flash_we_n, out, 1: write enable.
- flash_byte_n, out, 1: byte mode select; tied 1 (16-bit mode only).
- flash_vpen, out, 1: write protect / Vpp enable; tied 1.
- flash_rp_n, out, 1: reset/power-down; equals rst_n, registered.

Behaviour:
- Reset values:
  - flash_ce_n=1, flash_oe_n=1, flash_we_n=1, flash_rp_n=0.
  - flash_data released (Z), flash_address=0, bus_data_rd=0, bus_stall=0, state IDLE.
- flash_rp_n goes to 1 on the first clock after rst_n deasserts.
- States: IDLE, RD_LO, RD_HI, WR, DONE.
- IDLE:
  - bus_read=1 -> RD_LO; flash_address = {bus_address[ADDR_WIDTH-1:2],2'b00}.
  - Else bus_write=1 -> WR; flash_address = {bus_address[ADDR_WIDTH-1:1],1'b0}.
  - Read has priority when both request lines are set.
- RD_LO:
  - ce_n=0, oe_n=0, we_n=1, data bus released.
  - After READ_WAIT clocks, latch flash_data into bus_data_rd[15:0].
  - Set flash_address+=2; go to RD_HI.
- RD_HI:
  - Same timing as RD_LO.
  - Latch into bus_data_rd[31:16]; go to DONE.
- WR:
  - ce_n=0, we_n=0, oe_n=1; drive flash_data = bus_data_wr[15:0] for WRITE_WAIT clocks.
  - Then we_n=1 and ce_n=1 for one recovery clock, with data held through that clock.
  - Then go to DONE.
  - If bus_mask[1:0]==0, skip the flash cycle and go straight to DONE.
- DONE:
  - All strobes high, data released.
  - bus_stall=0 for exactly this cycle; bus_data_rd holds the read value.
  - Next state IDLE.
- bus_stall is combinational:
  - 1 when (bus_read|bus_write) and state!=DONE.
  - 0 when idle with no request.
- CPU must hold its request stable until it sees stall=0. A request still present when the controller returns to IDLE starts a new access.
- Total latency:
  - Read: 1 + 2*READ_WAIT + 1 clocks.
  - Write: 1 + WRITE_WAIT + 1 + 1 clocks.
- Little-endian word assembly: the lower halfword comes from the lower address.
- bus_data_rd keeps its last value until the next read completes.
- oe_n and we_n are never low simultaneously. flash_data is driven only in WR.
- rst_n asserted mid-access: abort immediately, all strobes high, data released, state IDLE.
- Request withdrawn mid-access: the access runs to DONE and the result is discarded.

Test Plan:
1. Reset: rst_n=0 -> ce_n/oe_n/we_n=1, rp_n=0, stall=0, flash_data=Z. Release rst_n -> rp_n=1 on the next clock.
2. Read at 0x000000, flash halfwords [0]=0x5678 and [1]=0x1234 -> stall high for 2*READ_WAIT+1 clocks, then bus_data_rd=0x12345678 with stall=0 for one cycle. flash_address sequence is 0x0 then 0x2.
3. Read at 0x000104 -> flash_address 0x104 then 0x106. Read at 0x000106 -> address aligned down to 0x104.
4. Write 0x00FF, mask 4'b0011, address 0x000AAA -> we_n low WRITE_WAIT clocks with flash_data=0x00FF and flash_address=0xAAA, oe_n stays high, then stall=0.
5. Write with mask 4'b1100 -> no we_n pulse, stall drops after 2 clocks.
6. Assert rst_n=0 during RD_HI -> strobes high at once; after release, a new read completes normally with correct data.

Source files
------------

// File: rtl/flash_controller.sv
// flash_controller: bus slave bridging 32-bit CPU reads/writes onto a 16-bit
// parallel NOR flash. Reads are assembled from two halfword accesses
// (low address -> low half). Writes issue one 16-bit command/data cycle.
module flash_controller #(
   parameter int READ_WAIT  = 8,
   parameter int WRITE_WAIT = 8,
   parameter int ADDR_WIDTH = 23
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  bus_read,
   input  logic                  bus_write,
   input  logic [31:0]           bus_address,
   input  logic [31:0]           bus_data_wr,
   input  logic [3:0]            bus_mask,
   output logic [31:0]           bus_data_rd,
   output logic                  bus_stall,
   output logic [ADDR_WIDTH-1:0] flash_address,
   inout  wire  [15:0]           flash_data,
   output logic                  flash_ce_n,
   output logic                  flash_oe_n,
   output logic                  flash_we_n,
   output logic                  flash_byte_n,
   output logic                  flash_vpen,
   output logic                  flash_rp_n
);

   typedef enum logic [2:0] {
      IDLE,
      RD_LO,
      RD_HI,
      WR,
      DONE
   } state_t;

   localparam int MAX_WAIT = (READ_WAIT > WRITE_WAIT) ? READ_WAIT : WRITE_WAIT;
   localparam int CNT_W    = $clog2(MAX_WAIT + 1);

   localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(READ_WAIT - 1);
   localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WRITE_WAIT - 1);

   state_t                state, state_nx;
   logic [CNT_W-1:0]      cnt, cnt_nx;
   logic                  recover, recover_nx;   // WR: strobes released, data still held
   logic [ADDR_WIDTH-1:0] addr, addr_nx;
   logic                  ce_n, ce_n_nx;
   logic                  oe_n, oe_n_nx;
   logic                  we_n, we_n_nx;
   logic                  drive, drive_nx;
   logic [15:0]           wr_data, wr_data_nx;
   logic [31:0]           data_rd, data_rd_nx;
   logic                  rp_n;

   // Bits of the bus request this 16-bit flash never looks at.
   logic unused_bits;
   assign unused_bits = ^{bus_address[31:ADDR_WIDTH], bus_address[0],
                          bus_data_wr[31:16], bus_mask[3:2]};

   // Next-state, next-strobe and datapath decode; strobes are registered so
   // the flash pins never see combinational glitches.
   always_comb begin
      // NOTE: every variable gets a default first so no path infers a latch.
      state_nx   = state;
      cnt_nx     = cnt;
      recover_nx = recover;
      addr_nx    = addr;
      wr_data_nx = wr_data;
      data_rd_nx = data_rd;
      ce_n_nx    = 1'b1;
      oe_n_nx    = 1'b1;
      we_n_nx    = 1'b1;
      drive_nx   = 1'b0;

      case (state)
         IDLE: begin
            cnt_nx     = '0;
            recover_nx = 1'b0;
            if (bus_read) begin
               state_nx = RD_LO;
               addr_nx  = {bus_address[ADDR_WIDTH-1:2], 2'b00};
               ce_n_nx  = 1'b0;
               oe_n_nx  = 1'b0;
            end else if (bus_write) begin
               state_nx   = WR;
               addr_nx    = {bus_address[ADDR_WIDTH-1:1], 1'b0};
               wr_data_nx = bus_data_wr[15:0];
               if (|bus_mask[1:0]) begin
                  ce_n_nx  = 1'b0;
                  we_n_nx  = 1'b0;
                  drive_nx = 1'b1;
               end else begin
                  // Nothing to write: pass through WR for one clock only.
                  recover_nx = 1'b1;
               end
            end
         end

         RD_LO: begin
            ce_n_nx = 1'b0;
            oe_n_nx = 1'b0;
            if (cnt == RD_LAST) begin
               data_rd_nx[15:0] = flash_data;
               addr_nx          = addr + ADDR_WIDTH'(2);
               cnt_nx           = '0;
               state_nx         = RD_HI;
            end else begin
               cnt_nx = cnt + 1'b1;
            end
         end

         RD_HI: begin
            if (cnt == RD_LAST) begin
               data_rd_nx[31:16] = flash_data;
               cnt_nx            = '0;
               state_nx          = DONE;
            end else begin
               ce_n_nx = 1'b0;
               oe_n_nx = 1'b0;
               cnt_nx  = cnt + 1'b1;
            end
         end

         WR: begin
            if (recover) begin
               state_nx   = DONE;
               recover_nx = 1'b0;
            end else if (cnt == WR_LAST) begin
               // Raise we_n/ce_n but keep data on the bus for hold time.
               recover_nx = 1'b1;
               drive_nx   = 1'b1;
               cnt_nx     = '0;
            end else begin
               ce_n_nx  = 1'b0;
               we_n_nx  = 1'b0;
               drive_nx = 1'b1;
               cnt_nx   = cnt + 1'b1;
            end
         end

         DONE: begin
            state_nx = IDLE;
         end

         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   // State and output registers; reset aborts any access with strobes high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         cnt     <= '0;
         recover <= 1'b0;
         addr    <= '0;
         ce_n    <= 1'b1;
         oe_n    <= 1'b1;
         we_n    <= 1'b1;
         drive   <= 1'b0;
         wr_data <= '0;
         data_rd <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state   <= state_nx;
         cnt     <= cnt_nx;
         recover <= recover_nx;
         addr    <= addr_nx;
         ce_n    <= ce_n_nx;
         oe_n    <= oe_n_nx;
         we_n    <= we_n_nx;
         drive   <= drive_nx;
         wr_data <= wr_data_nx;
         data_rd <= data_rd_nx;
      end
   end

   // Flash reset/power-down follows rst_n, released one clock after it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rp_n <= 1'b0;
      end else begin
         rp_n <= 1'b1;
      end
   end

   assign flash_data    = drive ? wr_data : 16'hzzzz;
   assign flash_address = addr;
   assign flash_ce_n    = ce_n;
   assign flash_oe_n    = oe_n;
   assign flash_we_n    = we_n;
   assign flash_byte_n  = 1'b1;
   assign flash_vpen    = 1'b1;
   assign flash_rp_n    = rp_n;
   assign bus_data_rd   = data_rd;
   assign bus_stall     = (bus_read | bus_write) && (state != DONE);

endmodule

// File: tb/tb_flash_controller.sv
// Directed bench for flash_controller with a small behavioural flash model.
module tb_flash_controller;

   localparam int RW = 3;
   localparam int WW = 4;
   localparam int AW = 23;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          bus_read = 1'b0;
   logic          bus_write = 1'b0;
   logic [31:0]   bus_address = '0;
   logic [31:0]   bus_data_wr = '0;
   logic [3:0]    bus_mask = '0;
   wire  [31:0]   bus_data_rd;
   wire           bus_stall;
   wire  [AW-1:0] flash_address;
   wire  [15:0]   flash_data;
   wire           flash_ce_n, flash_oe_n, flash_we_n;
   wire           flash_byte_n, flash_vpen, flash_rp_n;

   int tests = 0;
   int fails = 0;

   flash_controller #(.READ_WAIT(RW), .WRITE_WAIT(WW), .ADDR_WIDTH(AW)) dut (
      .clk(clk), .rst_n(rst_n),
      .bus_read(bus_read), .bus_write(bus_write),
      .bus_address(bus_address), .bus_data_wr(bus_data_wr), .bus_mask(bus_mask),
      .bus_data_rd(bus_data_rd), .bus_stall(bus_stall),
      .flash_address(flash_address), .flash_data(flash_data),
      .flash_ce_n(flash_ce_n), .flash_oe_n(flash_oe_n), .flash_we_n(flash_we_n),
      .flash_byte_n(flash_byte_n), .flash_vpen(flash_vpen), .flash_rp_n(flash_rp_n)
   );

   always #5 clk = ~clk;

   // Flash contents: halfword per even byte address.
   function automatic logic [15:0] flash_word(input logic [AW-1:0] a);
      case (a)
         23'h000000: return 16'h5678;
         23'h000002: return 16'h1234;
         23'h000104: return 16'hBEEF;
         23'h000106: return 16'hDEAD;
         23'h000200: return 16'hCAFE;
         23'h000202: return 16'hF00D;
         default:    return 16'h0BAD;
      endcase
   endfunction

   assign flash_data = (!flash_ce_n && !flash_oe_n) ? flash_word(flash_address) : 16'hzzzz;

   task automatic do_read(input string name, input logic [31:0] addr,
                          input logic [31:0] exp_data, input logic [AW-1:0] exp_a0);
      int n = 0;
      int changes = 0;
      bit have = 0;
      bit overlap = 0;
      logic [AW-1:0] last = '0;
      logic [AW-1:0] seen [2];
      seen[0] = '1;
      seen[1] = '1;
      @(posedge clk); #1;
      bus_read = 1'b1;
      bus_address = addr;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (!flash_oe_n && (!have || flash_address != last)) begin
            if (changes < 2) seen[changes] = flash_address;
            changes++;
            last = flash_address;
            have = 1;
         end
         if (!flash_oe_n && !flash_we_n) overlap = 1;
         if (!bus_stall) break;
         n++;
      end
      tests++;
      if (n !== 2*RW+1) begin
         fails++; $display("FAIL %s stall_cycles got %0d want %0d", name, n, 2*RW+1);
      end
      tests++;
      if (bus_data_rd !== exp_data) begin
         fails++; $display("FAIL %s data got %h want %h", name, bus_data_rd, exp_data);
      end
      tests++;
      if (changes !== 2 || seen[0] !== exp_a0 || seen[1] !== exp_a0 + AW'(2)) begin
         fails++; $display("FAIL %s addr_seq got %0d:%h,%h want 2:%h,%h", name, changes,
                           seen[0], seen[1], exp_a0, exp_a0 + AW'(2));
      end
      tests++;
      if (overlap !== 1'b0) begin
         fails++; $display("FAIL %s oe_we_overlap got 1 want 0", name);
      end
      @(posedge clk); #1;
      bus_read = 1'b0;
      @(negedge clk);
      tests++;
      if (bus_stall !== 1'b0 || bus_data_rd !== exp_data) begin
         fails++; $display("FAIL %s idle_hold got stall=%b data=%h want stall=0 data=%h",
                           name, bus_stall, bus_data_rd, exp_data);
      end
   endtask

   task automatic do_write(input string name, input logic [31:0] addr, input logic [15:0] data,
                           input logic [3:0] mask, input logic [AW-1:0] exp_addr,
                           input int exp_we, input int exp_stall);
      int n = 0;
      int we_cnt = 0;
      int rec = 0;
      bit bad_bus = 0;
      bit oe_low = 0;
      @(posedge clk); #1;
      bus_write = 1'b1;
      bus_address = addr;
      bus_data_wr = {16'hA5A5, data};
      bus_mask = mask;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (!flash_oe_n) oe_low = 1;
         if (!bus_stall) break;
         n++;
         if (!flash_we_n) begin
            we_cnt++;
            if (flash_data !== data || flash_address !== exp_addr || flash_ce_n !== 1'b0)
               bad_bus = 1;
         end else if (we_cnt > 0) begin
            rec++;
            if (flash_data !== data || flash_ce_n !== 1'b1) bad_bus = 1;
         end
      end
      tests++;
      if (n !== exp_stall) begin
         fails++; $display("FAIL %s stall_cycles got %0d want %0d", name, n, exp_stall);
      end
      tests++;
      if (we_cnt !== exp_we) begin
         fails++; $display("FAIL %s we_low_cycles got %0d want %0d", name, we_cnt, exp_we);
      end
      tests++;
      if (rec !== ((exp_we > 0) ? 1 : 0)) begin
         fails++; $display("FAIL %s recovery_cycles got %0d want %0d", name, rec,
                           (exp_we > 0) ? 1 : 0);
      end
      tests++;
      if (bad_bus !== 1'b0 || oe_low !== 1'b0) begin
         fails++; $display("FAIL %s bus_during_write got bad=%b oe_low=%b want 0,0",
                           name, bad_bus, oe_low);
      end
      @(posedge clk); #1;
      bus_write = 1'b0;
      bus_mask = '0;
   endtask

   task automatic test_reset();
      #12;
      @(negedge clk);
      tests++;
      if ({flash_ce_n, flash_oe_n, flash_we_n, flash_rp_n} !== 4'b1110) begin
         fails++; $display("FAIL reset_strobes got ce/oe/we/rp=%b%b%b%b want 1110",
                           flash_ce_n, flash_oe_n, flash_we_n, flash_rp_n);
      end
      tests++;
      if (bus_stall !== 1'b0 || bus_data_rd !== 32'h0 || flash_address !== '0) begin
         fails++; $display("FAIL reset_bus got stall=%b data=%h addr=%h want 0,0,0",
                           bus_stall, bus_data_rd, flash_address);
      end
      tests++;
      if (flash_byte_n !== 1'b1 || flash_vpen !== 1'b1) begin
         fails++; $display("FAIL reset_ties got byte_n=%b vpen=%b want 1,1",
                           flash_byte_n, flash_vpen);
      end
      rst_n = 1'b1;
      #1;
      tests++;
      if (flash_rp_n !== 1'b0) begin
         fails++; $display("FAIL rp_before_clock got %b want 0", flash_rp_n);
      end
      @(posedge clk); #1;
      tests++;
      if (flash_rp_n !== 1'b1) begin
         fails++; $display("FAIL rp_after_clock got %b want 1", flash_rp_n);
      end
   endtask

   task automatic test_read();
      do_read("read_0", 32'h0000_0000, 32'h1234_5678, 23'h000000);
      do_read("read_104", 32'h0000_0104, 32'hDEAD_BEEF, 23'h000104);
      do_read("read_106", 32'h0000_0106, 32'hDEAD_BEEF, 23'h000104);
   endtask

   task automatic test_write();
      do_write("write_aaa", 32'h0000_0AAA, 16'h00FF, 4'b0011, 23'h000AAA, WW, WW + 2);
      do_write("write_odd", 32'h0000_0555, 16'h0090, 4'b0001, 23'h000554, WW, WW + 2);
      do_write("write_nomask", 32'h0000_0AAA, 16'h1234, 4'b1100, 23'h000AAA, 0, 2);
      @(negedge clk);
      tests++;
      if (bus_data_rd !== 32'hDEAD_BEEF) begin
         fails++; $display("FAIL rd_hold_after_writes got %h want deadbeef", bus_data_rd);
      end
   endtask

   task automatic test_reset_mid_read();
      @(posedge clk); #1;
      bus_read = 1'b1;
      bus_address = 32'h0000_0200;
      repeat (RW + 2) @(negedge clk);   // now inside RD_HI
      tests++;
      if (flash_oe_n !== 1'b0 || flash_address !== 23'h000202) begin
         fails++; $display("FAIL midread_in_hi got oe_n=%b addr=%h want 0,000202",
                           flash_oe_n, flash_address);
      end
      rst_n = 1'b0;
      #1;
      tests++;
      if ({flash_ce_n, flash_oe_n, flash_we_n, flash_rp_n} !== 4'b1110) begin
         fails++; $display("FAIL midread_abort got ce/oe/we/rp=%b%b%b%b want 1110",
                           flash_ce_n, flash_oe_n, flash_we_n, flash_rp_n);
      end
      bus_read = 1'b0;
      #1;
      tests++;
      if (bus_stall !== 1'b0 || bus_data_rd !== 32'h0) begin
         fails++; $display("FAIL midread_cleared got stall=%b data=%h want 0,0",
                           bus_stall, bus_data_rd);
      end
      @(negedge clk);
      rst_n = 1'b1;
      do_read("read_after_reset", 32'h0000_0200, 32'hF00D_CAFE, 23'h000200);
   endtask

   initial begin
      test_reset();
      test_read();
      test_write();
      test_reset_mid_read();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got no finish want finish");
      $fatal(1, "timeout");
   end

endmodule
